sram_rr_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the single-port `sram_wrapper` (ADDR_W=12, DATA_W=16). It accepts read/write requests from two masters over valid/ready handshakes and issues at most one SRAM operation per cycle. It compensates for the wrapper's registered write-data input by driving write data one cycle ahead of address and enable. It routes fixed-latency read data back to the requesting port.

---
 rtl/sram_rr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port SRAM wrapper.
// Write data leads address/enable by one cycle because the wrapper registers
// its write-data input. Read data returns at a fixed latency of 3 cycles from
// acceptance and is steered to the requesting port by a tag pipeline.
module sram_rr_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_wmode,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_wmode,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic              prio;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;

    logic              iss_en;
    logic              iss_wmode;
    logic              iss_port;
    logic [ADDR_W-1:0] iss_addr;

    logic              tag1_rd;
    logic              tag1_port;
    logic              tag2_rd;
    logic              tag2_port;

    // Grant decision: single requester wins outright, a tie goes to prio.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !hold) begin
            if (p0_valid && (!p1_valid || !prio)) begin
                gnt0 = 1'b1;
            end else if (p1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Write data goes out in the grant cycle so the wrapper's input register
    // presents it alongside the issued address one cycle later.
    always_comb begin
        sram_wdata = '0;
        if (gnt0) begin
            sram_wdata = p0_wdata;
        end else if (gnt1) begin
            sram_wdata = p1_wdata;
        end
    end

    // Priority pointer: after serving port k, favour the other port.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (gnt_any) begin
            prio <= ~gnt1;
        end
    end

    // Issue register: drives the SRAM command one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_en    <= 1'b0;
            iss_wmode <= 1'b0;
            iss_addr  <= '0;
            iss_port  <= 1'b0;
        end else begin
            iss_en <= gnt_any;
            if (gnt_any) begin
                iss_wmode <= gnt1 ? p1_wmode : p0_wmode;
                iss_addr  <= gnt1 ? p1_addr  : p0_addr;
                iss_port  <= gnt1;
            end
        end
    end

    assign sram_en    = iss_en;
    assign sram_wmode = iss_wmode;
    assign sram_addr  = iss_addr;

    // Tag pipeline matching the wrapper's two-cycle read path; clearing it on
    // reset masks whatever the unreset wrapper data registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_rd   <= 1'b0;
            tag1_port <= 1'b0;
            tag2_rd   <= 1'b0;
            tag2_port <= 1'b0;
        end else begin
            tag1_rd   <= iss_en & ~iss_wmode;
            tag1_port <= iss_port;
            tag2_rd   <= tag1_rd;
            tag2_port <= tag1_port;
        end
    end

    assign p0_rvalid = tag2_rd & ~tag2_port;
    assign p1_rvalid = tag2_rd &  tag2_port;
    assign p0_rdata  = p0_rvalid ? sram_rdata : '0;
    assign p1_rdata  = p1_rvalid ? sram_rdata : '0;

endmodule
